// File: rtl/uart_frame_tx.sv
// Serializes one FRAME_BYTES*DBITS result word onto the UART tx pin, 8N1, least significant byte first.
// Define UART_FRAME_TX_TERM_EN to append a 0x0A terminator byte after the frame.
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BYTES  = 8,
    parameter int DBITS        = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FRAME_BYTES*DBITS-1:0] frame_value,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    output logic                         tx,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int FW     = FRAME_BYTES * DBITS;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DBITS + 1);
`ifdef UART_FRAME_TX_TERM_EN
    localparam int NUM_BYTES = FRAME_BYTES + 1;
`else
    localparam int NUM_BYTES = FRAME_BYTES;
`endif
    localparam int BYTE_W = $clog2(NUM_BYTES + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [FW-1:0]     shreg_q, shreg_d;
    logic [FW-1:0]     shreg_shift;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end     = (baud_q == BAUD_LAST);
    assign shreg_shift = shreg_q >> 1;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        // The baud counter free-runs through every bit of a frame; inputs never restart it.
        if (state_q != IDLE)
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            IDLE: begin
                if (frame_valid && ready_q) begin
                    shreg_d = frame_value;
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_shift;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shreg_shift[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        byte_d  = '0;
                    end else begin
                        state_d = START;
                        tx_d    = 1'b0;
                        byte_d  = byte_q + BYTE_W'(1);
`ifdef UART_FRAME_TX_TERM_EN
                        // Frame word is fully shifted out here, so the terminator drops into the low byte.
                        if (byte_q == BYTE_W'(FRAME_BYTES - 1))
                            shreg_d[DBITS-1:0] = DBITS'(8'h0A);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx          = tx_q;
    assign frame_ready = ready_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at CLKS_PER_BIT=4: cycle-exact line checks plus byte decode.
module tb_uart_frame_tx;

    localparam int CPB = 4;
    localparam int FB  = 8;
    localparam int DB  = 8;
`ifdef UART_FRAME_TX_TERM_EN
    localparam int NB = FB + 1;
`else
    localparam int NB = FB;
`endif
    localparam int BYTE_CYC = (DB + 2) * CPB;
    localparam int FT       = NB * BYTE_CYC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] frame_value = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready, tx, busy, frame_done;

    int asserts = 0;
    int fails   = 0;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .DBITS(DB)) dut (
        .clk(clk), .reset(reset), .frame_value(frame_value), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Called at #1 after accept edge; walks the whole frame cycle by cycle, ends at #1 after completion edge.
    task automatic run_frame(input logic [63:0] w, input bit scramble, output int errs, output logic [71:0] dec);
        errs = 0;
        dec  = '0;
        for (int t = 0; t < FT; t++) begin
            int k, ph;
            logic [7:0] b;
            logic exp_bit;
            k  = t / BYTE_CYC;
            ph = (t % BYTE_CYC) / CPB;
            b  = (k >= FB) ? 8'h0A : w[k*8 +: 8];
            exp_bit = (ph == 0) ? 1'b0 : (ph == DB + 1) ? 1'b1 : b[ph-1];
            if (tx !== exp_bit || busy !== 1'b1 || frame_ready !== 1'b0 || frame_done !== 1'b0)
                errs++;
            if (ph >= 1 && ph <= DB && (t % CPB) == CPB / 2)
                dec[k*8 + ph - 1] = tx;
            if (scramble) begin
                frame_valid = 1'($urandom_range(0, 1));
                frame_value = {$urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        if (scramble) frame_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        asserts++;
        if ({tx, frame_ready, busy, frame_done} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_async: {tx,ready,busy,done}=%b required 1100", {tx, frame_ready, busy, frame_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                if (tx !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0) bad++;
                @(posedge clk); #1;
            end
            asserts++;
            if (bad != 0) begin
                fails++;
                $display("FAIL idle_hold: %0d bad idle cycles, required 0", bad);
            end
        end
    endtask

    task automatic test_single;
        int errs;
        logic [71:0] dec;
        frame_value = 64'h0123456789ABCDEF;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        asserts++;
        if (tx !== 1'b0 || busy !== 1'b1 || frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: tx=%b busy=%b ready=%b required 0 1 0", tx, busy, frame_ready);
        end
        run_frame(64'h0123456789ABCDEF, 1'b0, errs, dec);
        asserts++;
        if (errs != 0) begin
            fails++;
            $display("FAIL single_bits: %0d bad cycles, required 0", errs);
        end
        asserts++;
        if (dec[63:0] !== {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}) begin
            fails++;
            $display("FAIL single_bytes: got %h required 0123456789abcdef", dec[63:0]);
        end
        asserts++;
        if ({tx, frame_ready, busy, frame_done} !== 4'b1101) begin
            fails++;
            $display("FAIL single_done: {tx,ready,busy,done}=%b required 1101", {tx, frame_ready, busy, frame_done});
        end
        @(posedge clk); #1;
        asserts++;
        if (frame_done !== 1'b0 || frame_ready !== 1'b1 || tx !== 1'b1) begin
            fails++;
            $display("FAIL single_done_pulse: done=%b ready=%b tx=%b required 0 1 1", frame_done, frame_ready, tx);
        end
    endtask

    task automatic test_reset_mid;
        int errs;
        logic [71:0] dec;
        frame_value = 64'hFFFFFFFF00FFFFFF;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (3 * BYTE_CYC + CPB + 2) @(posedge clk);
        #1;
        asserts++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL mid_precond: tx=%b required 0", tx);
        end
        #2 reset = 1'b1;
        #1;
        asserts++;
        if ({tx, frame_ready, busy, frame_done} !== 4'b1100) begin
            fails++;
            $display("FAIL mid_reset: {tx,ready,busy,done}=%b required 1100", {tx, frame_ready, busy, frame_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        asserts++;
        if (frame_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: ready=%b tx=%b busy=%b required 1 1 0", frame_ready, tx, busy);
        end
        frame_value = 64'h00000000000000FF;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        run_frame(64'h00000000000000FF, 1'b0, errs, dec);
        asserts++;
        if (errs != 0 || dec[63:0] !== {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}) begin
            fails++;
            $display("FAIL mid_newframe: %0d bad cycles, bytes %h required 0 / 00000000000000ff", errs, dec[63:0]);
        end
    endtask

    task automatic test_back_to_back;
        int errs1, errs2;
        logic [71:0] dec1, dec2;
        frame_value = 64'h1111111111111111;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_value = 64'h2222222222222222;
        run_frame(64'h1111111111111111, 1'b0, errs1, dec1);
        asserts++;
        if ({tx, frame_ready, busy, frame_done} !== 4'b1101) begin
            fails++;
            $display("FAIL b2b_gap: {tx,ready,busy,done}=%b required 1101", {tx, frame_ready, busy, frame_done});
        end
        @(posedge clk); #1;
        frame_valid = 1'b0;
        asserts++;
        if (tx !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: tx=%b busy=%b done=%b required 0 1 0", tx, busy, frame_done);
        end
        run_frame(64'h2222222222222222, 1'b0, errs2, dec2);
        asserts++;
        if (errs1 != 0 || errs2 != 0) begin
            fails++;
            $display("FAIL b2b_bits: %0d / %0d bad cycles, required 0 / 0", errs1, errs2);
        end
        asserts++;
        if (dec1[63:0] !== {8{8'h11}} || dec2[63:0] !== {8{8'h22}}) begin
            fails++;
            $display("FAIL b2b_bytes: got %h %h required 1111111111111111 2222222222222222", dec1[63:0], dec2[63:0]);
        end
    endtask

    task automatic test_stability;
        int errs;
        logic [71:0] dec;
        frame_value = 64'hA5C30F961E2D3C4B;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        run_frame(64'hA5C30F961E2D3C4B, 1'b1, errs, dec);
        asserts++;
        if (errs != 0 || dec[63:0] !== {8'hA5, 8'hC3, 8'h0F, 8'h96, 8'h1E, 8'h2D, 8'h3C, 8'h4B}) begin
            fails++;
            $display("FAIL stability: %0d bad cycles, bytes %h required 0 / a5c30f961e2d3c4b", errs, dec[63:0]);
        end
        asserts++;
        if (frame_done !== 1'b1 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL stability_done: done=%b ready=%b required 1 1", frame_done, frame_ready);
        end
        @(posedge clk); #1;
    endtask

`ifdef UART_FRAME_TX_TERM_EN
    task automatic test_term;
        int errs;
        logic [71:0] dec;
        frame_value = 64'h0;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        run_frame(64'h0, 1'b0, errs, dec);
        asserts++;
        if (errs != 0 || dec !== {8'h0A, 64'h0}) begin
            fails++;
            $display("FAIL term: %0d bad cycles, bytes %h required 0 / 0a0000000000000000", errs, dec);
        end
        asserts++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL term_done: done=%b required 1 at 360 cycles", frame_done);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_reset_mid;
        test_back_to_back;
        test_stability;
`ifdef UART_FRAME_TX_TERM_EN
        test_term;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
